aes_mix_columns_seq: RTL and testbench



---
 rtl/aes_pkg.sv | 21 ++
 rtl/aes_mix_lane.sv | 38 +++
 rtl/aes_mix_columns_seq.sv | 113 +++++++++++
 tb/tb_aes_mix_columns_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, constants and byte indexing for the MixColumns stage
package aes_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] col_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam int NUM_COLS = 4;
  localparam int LATENCY  = 5;

  // LSB position of byte s(r,c) in a column-major 128-bit state (s(0,0) is the top byte)
  function automatic int byte_lsb(input int r, input int c);
    return 120 - 8 * (4 * c + r);
  endfunction

endpackage

// File: rtl/aes_mix_lane.sv
// rtl/aes_mix_lane.sv - one output row: registered x2/x3 lookups plus the 4-input XOR
module aes_mix_lane
  import aes_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  rd_en,
  input  byte_t addr2,
  input  byte_t addr3,
  input  byte_t plain2,
  input  byte_t plain3,
  output byte_t mixed
);

  byte_t m2_q;
  byte_t m3_q;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Lookups read as 0x00 whenever they are not enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      m2_q <= 8'h00;
      m3_q <= 8'h00;
    end else if (rd_en) begin
      m2_q <= xtime(addr2);
      m3_q <= xtime(addr3) ^ addr3;
    end else begin
      m2_q <= 8'h00;
      m3_q <= 8'h00;
    end
  end

  assign mixed = m2_q ^ m3_q ^ plain2 ^ plain3;

endmodule

// File: rtl/aes_mix_columns_seq.sv
// rtl/aes_mix_columns_seq.sv - column-serial MixColumns, one column per cycle, Done after 5 clocks
// Optional AES_MIXCOL_LAST_ROUND_EN adds Last_Round, which passes the latched state through unmixed.
module aes_mix_columns_seq
  import aes_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         Start,
  input  logic [127:0] State_In,
`ifdef AES_MIXCOL_LAST_ROUND_EN
  input  logic         Last_Round,
`endif
  output logic         Busy,
  output logic         Done,
  output logic [127:0] State_Out
);

  state_t       state;
  state_t       state_nxt;
  logic [1:0]   col;
  logic [1:0]   col_d;
  logic         issue_v;
  logic         rd_en;
  logic         bypass;
  logic [127:0] in_reg;
  byte_t        lane_out [NUM_COLS];
  col_t         mixed_col;
  col_t         plain_col;

`ifdef AES_MIXCOL_LAST_ROUND_EN
  logic last_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_reg <= 1'b0;
    end else if (state == IDLE && Start) begin
      last_reg <= Last_Round;
    end
  end

  assign bypass = last_reg;
`else
  assign bypass = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_nxt = ISSUE;
      end
      ISSUE: begin
        rd_en = 1'b1;
        if (col == 2'(NUM_COLS - 1)) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Addresses follow the issuing column; plain bytes follow the column whose ROM data is now valid
  for (genvar r = 0; r < NUM_COLS; r++) begin : g_lane
    aes_mix_lane u_lane (
      .clk    (CLK),
      .rst    (RST),
      .rd_en  (rd_en),
      .addr2  (in_reg[byte_lsb(r, int'(col)) +: 8]),
      .addr3  (in_reg[byte_lsb((r + 1) % NUM_COLS, int'(col)) +: 8]),
      .plain2 (in_reg[byte_lsb((r + 2) % NUM_COLS, int'(col_d)) +: 8]),
      .plain3 (in_reg[byte_lsb((r + 3) % NUM_COLS, int'(col_d)) +: 8]),
      .mixed  (lane_out[r])
    );
  end

  assign mixed_col = {lane_out[0], lane_out[1], lane_out[2], lane_out[3]};
  assign plain_col = in_reg[byte_lsb(3, int'(col_d)) +: 32];

  always_ff @(posedge CLK) begin
    if (RST) begin
      in_reg    <= '0;
      col       <= 2'd0;
      col_d     <= 2'd0;
      issue_v   <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      State_Out <= '0;
    end else begin
      issue_v <= rd_en;
      col_d   <= col;
      Done    <= (state == DRAIN);
      if (state == IDLE && Start) begin
        in_reg <= State_In;
        col    <= 2'd0;
        Busy   <= 1'b1;
      end
      if (state == ISSUE) col <= col + 2'd1;
      if (state == DRAIN) Busy <= 1'b0;
      if (issue_v) begin
        State_Out[byte_lsb(3, int'(col_d)) +: 32] <= bypass ? plain_col : mixed_col;
      end
    end
  end

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// tb/tb_aes_mix_columns_seq.sv - scoreboard bench for aes_mix_columns_seq
module tb_aes_mix_columns_seq;
  import aes_pkg::*;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         Start = 1'b0;
  logic [127:0] State_In = '0;
  logic         Busy;
  logic         Done;
  logic [127:0] State_Out;
`ifdef AES_MIXCOL_LAST_ROUND_EN
  logic         Last_Round = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int done_count = 0;
  int exp_dones = 0;
  logic busy_s = 1'b0;
  logic [127:0] exp_q [$];
  int acc_q [$];

  localparam logic [127:0] V1_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] V1_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] V2_IN  = 128'hdb135345f20a225cc6c6c6c601010101;
  localparam logic [127:0] V2_OUT = 128'h8e4da1bc9fdc589dc6c6c6c601010101;
  localparam logic [127:0] V3_IN  = 128'hdb135345000000000000000000000000;
  localparam logic [127:0] V3_OUT = 128'h8e4da1bc000000000000000000000000;

  aes_mix_columns_seq dut (
    .CLK       (CLK),
    .RST       (RST),
    .Start     (Start),
    .State_In  (State_In),
`ifdef AES_MIXCOL_LAST_ROUND_EN
    .Last_Round(Last_Round),
`endif
    .Busy      (Busy),
    .Done      (Done),
    .State_Out (State_Out)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] model_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127 - 8 * (4 * c + r) -: 8];
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = gm2(a[r]) ^ gm2(a[(r + 1) % 4]) ^ a[(r + 1) % 4]
                                        ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
      end
    end
    return o;
  endfunction

  // Acceptance is predicted from inputs plus Busy as sampled on the previous falling edge
  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (RST) begin
      exp_q.delete();
      acc_q.delete();
      busy_cnt = 0;
    end else if (Start && !busy_s) begin
`ifdef AES_MIXCOL_LAST_ROUND_EN
      exp_q.push_back(Last_Round ? State_In : model_mix(State_In));
`else
      exp_q.push_back(model_mix(State_In));
`endif
      acc_q.push_back(cyc);
    end
  end

  always @(negedge CLK) begin
    busy_s = Busy;
    if (Busy) busy_cnt++;
    if (Done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_done", 128'd1, 128'd0);
      end else begin
        check_val("sb_state_out", State_Out, exp_q.pop_front());
        check_val("sb_latency", 128'(cyc - acc_q.pop_front()), 128'(LATENCY));
        check_val("sb_busy_cycles", 128'(busy_cnt), 128'(LATENCY));
      end
      busy_cnt = 0;
    end
  end

  task automatic start_op(input logic [127:0] v);
    @(posedge CLK); #1;
    Start = 1'b1;
    State_In = v;
    @(posedge CLK); #1;
    Start = 1'b0;
    exp_dones++;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (Done) break;
    end
    check_val(tag, 128'(Done), 128'd1);
  endtask

  initial begin
    logic [127:0] rv;
    int dc;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    check_val("reset_busy", 128'(Busy), 128'd0);
    check_val("reset_done", 128'(Done), 128'd0);
    check_val("reset_state_out", State_Out, 128'd0);

    start_op(V1_IN);
    wait_done("v1_done");
    check_val("v1_out", State_Out, V1_OUT);

    start_op(V2_IN);
    wait_done("cols_done");
    check_val("cols_out", State_Out, V2_OUT);

    start_op(V3_IN);
    wait_done("single_col_done");
    check_val("single_col_out", State_Out, V3_OUT);

    // Second Start raised in the Done cycle
    start_op(V2_IN);
    wait_done("b2b_first_done");
    #1;
    Start = 1'b1;
    State_In = V1_IN;
    @(posedge CLK); #1;
    Start = 1'b0;
    exp_dones++;
    wait_done("b2b_second_done");
    check_val("b2b_second_out", State_Out, V1_OUT);

    // Start mid-operation must be ignored
    start_op(V3_IN);
    @(posedge CLK); #1;
    Start = 1'b1;
    State_In = V1_IN;
    @(posedge CLK); #1;
    Start = 1'b0;
    wait_done("midop_done");
    check_val("midop_out", State_Out, V3_OUT);

    // Reset at E3 aborts
    start_op(V1_IN);
    exp_dones--;
    dc = done_count;
    @(posedge CLK);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check_val("abort_busy", 128'(Busy), 128'd0);
    check_val("abort_done", 128'(Done), 128'd0);
    check_val("abort_state_out", State_Out, 128'd0);
    repeat (8) @(negedge CLK);
    check_val("abort_no_done", 128'(done_count), 128'(dc));

    start_op(V2_IN);
    wait_done("post_abort_done");
    check_val("post_abort_out", State_Out, V2_OUT);

    // State_In churns after acceptance
    start_op(V1_IN);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (Done) break;
      State_In = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    check_val("churn_done", 128'(Done), 128'd1);
    check_val("churn_out", State_Out, V1_OUT);

    for (int k = 0; k < 3; k++) begin
      rv = {$urandom(), $urandom(), $urandom(), $urandom()};
      start_op(rv);
      wait_done("rand_done");
      check_val("rand_out", State_Out, model_mix(rv));
    end

`ifdef AES_MIXCOL_LAST_ROUND_EN
    Last_Round = 1'b1;
    start_op(V1_IN);
    @(posedge CLK); #1 Last_Round = 1'b0;
    wait_done("last_round_done");
    check_val("last_round_out", State_Out, V1_IN);
    start_op(V1_IN);
    wait_done("not_last_done");
    check_val("not_last_out", State_Out, V1_OUT);
`endif

    repeat (3) @(negedge CLK);
    check_val("sb_empty", 128'(exp_q.size()), 128'd0);
    check_val("done_total", 128'(done_count), 128'(exp_dones));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
